// File: rtl/apb_master_bridge_if.sv
// APB bus bundle shared by the bridge and its slaves.
// Master drives the request side, slave drives ready/data/error.
interface apb_intf #(
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to single APB transfer bridge with one buffered
// response and an optional pready timeout.
module apb_master_bridge #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    apb_intf.master           apb
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int CNT_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [31:0]       r_pwdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_to;

    logic w_accept;
    logic w_expire;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_expire  = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_SETUP;
                        r_cnt    <= '0;
                        r_pwrite <= req_write;
                        r_paddr  <= req_addr;
                        r_pwdata <= req_wdata;
                    end
                end
                S_SETUP: begin
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (apb.pready) begin
                        r_state <= S_RESP;
                        r_rdata <= r_pwrite ? 32'd0 : apb.prdata;
                        r_err   <= apb.pslverr;
                        r_to    <= 1'b0;
                    end else if (w_expire) begin
                        // abort: slave is assumed side-effect-free here
                        r_state <= S_RESP;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_to    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign apb.psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign apb.penable = (r_state == S_ACCESS);
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;

    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_to;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model checked every
// cycle, plus hand-computed latency and data expectations.
module tb_apb_master_bridge;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_intf #(.ADDR_W(32)) apb ();

    apb_master_bridge #(
        .ADDR_W     (32),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .apb        (apb)
    );

    // bench slave: pready after sl_wait wait states unless hung
    int          sl_wait = 0;
    int          acc_cnt = 0;
    logic        sl_hang = 1'b0;
    logic        sl_err = 1'b0;
    logic        sl_force = 1'b0;
    logic [31:0] sl_rdata = 32'd0;

    always @(posedge clk) begin
        if (apb.psel && apb.penable && !apb.pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign apb.pready  = sl_force |
        (apb.psel & apb.penable & !sl_hang & (acc_cnt == sl_wait));
    assign apb.prdata  = sl_rdata;
    assign apb.pslverr = sl_err;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction model: m_age counts cycles since accept
    logic        m_busy = 1'b0;
    logic        m_rsp = 1'b0;
    int          m_age = 0;
    logic        m_wr = 1'b0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;
    logic        m_to = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 1'b0;
            m_rsp  = 1'b0;
            m_age  = 0;
        end else if (m_rsp) begin
            if (rsp_ready) m_rsp = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2) begin
                if (apb.pready) begin
                    m_rsp   = 1'b1;
                    m_busy  = 1'b0;
                    m_rdata = m_wr ? 32'd0 : apb.prdata;
                    m_err   = apb.pslverr;
                    m_to    = 1'b0;
                end else if (TO != 0 && m_age - 2 == TO - 1) begin
                    m_rsp   = 1'b1;
                    m_busy  = 1'b0;
                    m_rdata = 32'd0;
                    m_err   = 1'b1;
                    m_to    = 1'b1;
                end
            end
            m_age++;
        end else if (req_valid) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_wr    = req_write;
            m_addr  = req_addr;
            m_wdata = req_wdata;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_rsp));
            chk("psel", 32'(apb.psel), 32'(m_busy));
            chk("penable", 32'(apb.penable), 32'(m_busy && m_age >= 2));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
            if (m_busy) begin
                chk("paddr", apb.paddr, m_addr);
                chk("pwdata", apb.pwdata, m_wdata);
                chk("pwrite", 32'(apb.pwrite), 32'(m_wr));
            end
            if (m_rsp) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
            end
        end
    end

    int          r_accw;
    int          r_lat;
    int          r_npen;
    logic [31:0] r_rd;
    logic        r_err;
    logic        r_to;

    task automatic do_req(
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          wt,
        input  logic        err,
        input  logic [31:0] rd,
        input  logic        hang,
        input  int          rdly,
        input  logic        hold_next,
        output int          accw,
        output int          lat,
        output int          npen,
        output logic [31:0] o_rd,
        output logic        o_err,
        output logic        o_to
    );
        sl_wait   = wt;
        sl_err    = err;
        sl_rdata  = rd;
        sl_hang   = hang;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        accw = 0;
        lat  = 0;
        npen = 0;
        o_rd = 32'd0;
        o_err = 1'b0;
        o_to  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
            accw++;
        end
        if (accw >= 50) chk("accept_bound", 32'(accw), 32'd0);
        @(posedge clk);
        #1;
        if (hold_next) begin
            req_addr  = addr + 32'h100;
            req_wdata = ~wdata;
        end else begin
            req_valid = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (apb.penable) npen++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) chk("rsp_bound", 32'(rsp_valid), 32'd1);
        o_rd  = rsp_rdata;
        o_err = rsp_err;
        o_to  = rsp_timeout;
        for (int i = 0; i < rdly; i++) begin
            sl_force = hang;
            @(negedge clk);
        end
        sl_force  = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1 rstn = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_psel", 32'(apb.psel), 32'd0);
        chk("rst_penable", 32'(apb.penable), 32'd0);
        chk("rst_pwrite", 32'(apb.pwrite), 32'd0);
        chk("rst_paddr", apb.paddr, 32'd0);
        chk("rst_pwdata", apb.pwdata, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_to", 32'(rsp_timeout), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h0000_0004, 32'h8000_0000, 0, 1'b0, 32'hFFFF_FFFF,
               1'b0, 0, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("wr_lat", 32'(r_lat), 32'd3);
        chk("wr_npen", 32'(r_npen), 32'd1);
        chk("wr_rdata", r_rd, 32'd0);
        chk("wr_err", 32'(r_err), 32'd0);
        chk("wr_to", 32'(r_to), 32'd0);

        do_req(1'b0, 32'h0000_0008, 32'h0, 3, 1'b0, 32'h2000_0000,
               1'b0, 1, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("rdw_lat", 32'(r_lat), 32'd6);
        chk("rdw_npen", 32'(r_npen), 32'd4);
        chk("rdw_rdata", r_rd, 32'h2000_0000);
        chk("rdw_err", 32'(r_err), 32'd0);

        do_req(1'b0, 32'h0000_000C, 32'h0, 0, 1'b1, 32'hDEAD_BEEF,
               1'b0, 0, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("serr_lat", 32'(r_lat), 32'd3);
        chk("serr_rdata", r_rd, 32'hDEAD_BEEF);
        chk("serr_err", 32'(r_err), 32'd1);
        chk("serr_to", 32'(r_to), 32'd0);

        do_req(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 32'h1111_1111,
               1'b1, 3, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("to_lat", 32'(r_lat), 32'd18);
        chk("to_npen", 32'(r_npen), 32'd16);
        chk("to_rdata", r_rd, 32'd0);
        chk("to_err", 32'(r_err), 32'd1);
        chk("to_to", 32'(r_to), 32'd1);
        sl_hang  = 1'b0;
        sl_force = 1'b1;
        @(negedge clk);
        chk("late_pready_psel", 32'(apb.psel), 32'd0);
        chk("late_pready_rsp", 32'(rsp_valid), 32'd0);
        sl_force = 1'b0;
        @(posedge clk);
        #1;

        do_req(1'b1, 32'h0000_0014, 32'h0000_1234, 0, 1'b0, 32'h0,
               1'b0, 5, 1'b1, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("bp_lat", 32'(r_lat), 32'd3);
        do_req(1'b1, 32'h0000_0020, 32'h5555_0000, 0, 1'b0, 32'h0,
               1'b0, 0, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("bp_next_accw", 32'(r_accw), 32'd0);
        chk("bp_next_lat", 32'(r_lat), 32'd3);

        sl_hang   = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0030;
        @(negedge clk);
        chk("mr_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_penable", 32'(apb.penable), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mr_psel", 32'(apb.psel), 32'd0);
        chk("mr_penable0", 32'(apb.penable), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd1);
        chk("mr_paddr", apb.paddr, 32'd0);
        sl_hang = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;

        do_req(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 1'b0, 32'h0,
               1'b0, 0, 1'b0, r_accw, r_lat, r_npen, r_rd, r_err, r_to);
        chk("post_rst_accw", 32'(r_accw), 32'd0);
        chk("post_rst_lat", 32'(r_lat), 32'd3);
        chk("post_rst_err", 32'(r_err), 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
